// File: rtl/core_lsu_pkg.sv
// core_lsu_pkg: shared funct3 size codes, strobe width and LSU FSM state encoding
package core_lsu_pkg;
  localparam logic [1:0] LSU_B = 2'b00;
  localparam logic [1:0] LSU_H = 2'b01;
  localparam logic [1:0] LSU_W = 2'b10;
  localparam logic [1:0] LSU_D = 2'b11;
  localparam int LSU_UNSIGNED = 2;
  localparam int LSU_STRB_WIDTH = 8;
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_BUSY = 2'd1, S_DONE = 2'd2} lsu_state_t;
endpackage

// File: rtl/core_lsu_align.sv
// core_lsu_align: store lane shift/strobes, access legality check, load extract and extend
module core_lsu_align
  import core_lsu_pkg::*;
#(
  parameter int XLEN = 64,
  parameter int BUS_W = 64
) (
  input  logic                      read,
  input  logic                      write,
  input  logic [2:0]                funct3,
  input  logic [2:0]                off,
  input  logic [XLEN-1:0]           wdata,
  input  logic [BUS_W-1:0]          rdata,
  output logic [BUS_W-1:0]          wdata_sh,
  output logic [LSU_STRB_WIDTH-1:0] wstrb,
  output logic                      fault,
  output logic [XLEN-1:0]           load_data
);
  logic [1:0] size;
  logic illegal, misal, sx;
  logic [LSU_STRB_WIDTH-1:0] mask;
  logic [BUS_W-1:0] shifted;
  always_comb begin
    size = funct3[1:0];
    illegal = read ? funct3 == 3'b111 : write & funct3[LSU_UNSIGNED];
    misal = size == LSU_H ? off[0] : size == LSU_W ? |off[1:0] : size == LSU_D ? |off : 1'b0;
    fault = (read | write) & (illegal | misal);
    mask = size == LSU_B ? 8'h01 : size == LSU_H ? 8'h03 : size == LSU_W ? 8'h0F : 8'hFF;
    wstrb = write ? mask << off : '0;
    wdata_sh = BUS_W'(wdata) << {off, 3'b000};
    shifted = rdata >> {off, 3'b000};
    sx = ~funct3[LSU_UNSIGNED];
    load_data = size == LSU_B ? {{(XLEN-8){sx & shifted[7]}}, shifted[7:0]} :
                size == LSU_H ? {{(XLEN-16){sx & shifted[15]}}, shifted[15:0]} :
                size == LSU_W ? {{(XLEN-32){sx & shifted[31]}}, shifted[31:0]} :
                XLEN'(shifted);
  end
endmodule

// File: rtl/core_lsu.sv
// core_lsu: MEM-stage load/store unit with single-outstanding req/ack bus and pipeline stall
// Ports: EX/MEM op inputs (mem_read_i/mem_write_i/funct3_i/addr_i/wdata_i/rsd_idx_i),
// bus req/ack interface (bus_*), lsu_stall_o/lsu_fault_o, and MEM/WB load result (load_*).
module core_lsu
  import core_lsu_pkg::*;
#(
  parameter int XLEN = 64,
  parameter int BUS_W = 64
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      mem_read_i,
  input  logic                      mem_write_i,
  input  logic [2:0]                funct3_i,
  input  logic [XLEN-1:0]           addr_i,
  input  logic [XLEN-1:0]           wdata_i,
  input  logic [4:0]                rsd_idx_i,
  output logic                      bus_req_o,
  output logic                      bus_we_o,
  output logic [XLEN-1:0]           bus_addr_o,
  output logic [BUS_W-1:0]          bus_wdata_o,
  output logic [LSU_STRB_WIDTH-1:0] bus_wstrb_o,
  input  logic                      bus_ack_i,
  input  logic [BUS_W-1:0]          bus_rdata_i,
  output logic                      lsu_stall_o,
  output logic                      lsu_fault_o,
  output logic                      load_valid_o,
  output logic [XLEN-1:0]           load_data_o,
  output logic [4:0]                load_rsd_idx_o
);
  lsu_state_t state;
  logic [2:0] f3_q, off_q;
  logic [4:0] idx_q;
  logic idle, a_read, a_write, a_fault;
  logic [2:0] a_f3, a_off;
  logic [BUS_W-1:0] a_wdata;
  logic [LSU_STRB_WIDTH-1:0] a_wstrb;
  logic [XLEN-1:0] a_load;
  // One aligner serves both paths: live inputs while idle, latched access while busy.
  always_comb begin
    idle = state == S_IDLE;
    a_read = idle ? mem_read_i : ~bus_we_o;
    a_write = idle ? mem_write_i : bus_we_o;
    a_f3 = idle ? funct3_i : f3_q;
    a_off = idle ? addr_i[2:0] : off_q;
    lsu_fault_o = ~rst & idle & a_fault;
    lsu_stall_o = ~rst & (state == S_BUSY | (idle & (mem_read_i | mem_write_i) & ~a_fault));
  end
  core_lsu_align #(.XLEN(XLEN), .BUS_W(BUS_W)) u_align (
    .read(a_read), .write(a_write), .funct3(a_f3), .off(a_off),
    .wdata(wdata_i), .rdata(bus_rdata_i),
    .wdata_sh(a_wdata), .wstrb(a_wstrb), .fault(a_fault), .load_data(a_load)
  );
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      bus_req_o <= 1'b0;
      bus_we_o <= 1'b0;
      bus_addr_o <= '0;
      bus_wdata_o <= '0;
      bus_wstrb_o <= '0;
      load_valid_o <= 1'b0;
      load_data_o <= '0;
      load_rsd_idx_o <= '0;
      f3_q <= '0;
      off_q <= '0;
      idx_q <= '0;
    end else begin
      case (state)
        S_IDLE: if ((mem_read_i | mem_write_i) & ~a_fault) begin
          bus_addr_o <= {addr_i[XLEN-1:3], 3'b000};
          bus_wdata_o <= a_wdata;
          bus_wstrb_o <= a_wstrb;
          bus_we_o <= mem_write_i;
          f3_q <= funct3_i;
          off_q <= addr_i[2:0];
          idx_q <= rsd_idx_i;
          bus_req_o <= 1'b1;
          state <= S_BUSY;
        end
        S_BUSY: if (bus_ack_i) begin
          bus_req_o <= 1'b0;
          if (!bus_we_o) begin
            load_data_o <= a_load;
            load_rsd_idx_o <= idx_q;
            load_valid_o <= 1'b1;
          end
          state <= S_DONE;
        end
        S_DONE: begin
          load_valid_o <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_core_lsu.sv
// tb_core_lsu: directed self-checking bench for core_lsu
module tb_core_lsu;
  logic clk = 0, rst = 1;
  logic mem_read_i = 0, mem_write_i = 0;
  logic [2:0] funct3_i = 0;
  logic [63:0] addr_i = 0, wdata_i = 0, bus_rdata_i = 0;
  logic [4:0] rsd_idx_i = 0;
  logic bus_ack_i = 0;
  logic bus_req_o, bus_we_o, lsu_stall_o, lsu_fault_o, load_valid_o;
  logic [63:0] bus_addr_o, bus_wdata_o, load_data_o;
  logic [7:0] bus_wstrb_o;
  logic [4:0] load_rsd_idx_o;
  int total = 0, bad = 0;
  logic [63:0] s_addr, s_wdata, d_ld;
  logic [7:0] s_wstrb;
  logic [4:0] d_li;
  logic s_we, s_req, stable, d_lv, d_req, a_lv, a_fault, a_req, f0;
  int stalls;

  always #5 clk = ~clk;

  core_lsu dut (
    .clk(clk), .rst(rst), .mem_read_i(mem_read_i), .mem_write_i(mem_write_i),
    .funct3_i(funct3_i), .addr_i(addr_i), .wdata_i(wdata_i), .rsd_idx_i(rsd_idx_i),
    .bus_req_o(bus_req_o), .bus_we_o(bus_we_o), .bus_addr_o(bus_addr_o),
    .bus_wdata_o(bus_wdata_o), .bus_wstrb_o(bus_wstrb_o), .bus_ack_i(bus_ack_i),
    .bus_rdata_i(bus_rdata_i), .lsu_stall_o(lsu_stall_o), .lsu_fault_o(lsu_fault_o),
    .load_valid_o(load_valid_o), .load_data_o(load_data_o), .load_rsd_idx_o(load_rsd_idx_o)
  );

  // Drives one access, acking on the waits-th busy cycle; records what it saw for the callers.
  task automatic run_op(input logic r, input logic w, input logic [2:0] f3, input logic [63:0] a,
                        input logic [63:0] wd, input logic [4:0] idx, input logic [63:0] rd, input int waits);
    int k = 0;
    @(negedge clk);
    mem_read_i = r; mem_write_i = w; funct3_i = f3; addr_i = a; wdata_i = wd;
    rsd_idx_i = idx; bus_rdata_i = rd;
    #1;
    f0 = lsu_fault_o; stalls = 0; stable = 1;
    while (lsu_stall_o && stalls < 50) begin
      stalls++;
      if (k == 1) begin
        s_req = bus_req_o; s_we = bus_we_o; s_addr = bus_addr_o; s_wdata = bus_wdata_o; s_wstrb = bus_wstrb_o;
      end else if (k > 1 && {bus_req_o, bus_we_o, bus_addr_o, bus_wdata_o, bus_wstrb_o} !== {s_req, s_we, s_addr, s_wdata, s_wstrb})
        stable = 0;
      bus_ack_i = (k >= 1 && k == waits);
      @(posedge clk);
      @(negedge clk);
      bus_ack_i = 0;
      k++;
    end
    d_lv = load_valid_o; d_ld = load_data_o; d_li = load_rsd_idx_o; d_req = bus_req_o;
    mem_read_i = 0; mem_write_i = 0;
    @(posedge clk);
    @(negedge clk);
    a_lv = load_valid_o; a_fault = lsu_fault_o; a_req = bus_req_o;
  endtask

  task automatic test_reset();
    #2;
    total++; if ({bus_req_o, bus_we_o, bus_addr_o, bus_wdata_o, bus_wstrb_o} !== '0) begin bad++; $display("FAIL reset_bus got=%h/%h/%h/%h/%h exp=0", bus_req_o, bus_we_o, bus_addr_o, bus_wdata_o, bus_wstrb_o); end
    total++; if ({load_valid_o, load_data_o, load_rsd_idx_o, lsu_stall_o, lsu_fault_o} !== '0) begin bad++; $display("FAIL reset_load got=%h/%h/%h/%h/%h exp=0", load_valid_o, load_data_o, load_rsd_idx_o, lsu_stall_o, lsu_fault_o); end
    @(negedge clk); rst = 0;
  endtask

  task automatic test_lw();
    run_op(1, 0, 3'b010, 64'h1004, 0, 5, 64'h8000_0001_1234_5678, 1);
    total++; if (s_addr !== 64'h1000) begin bad++; $display("FAIL lw_addr got=%h exp=%h", s_addr, 64'h1000); end
    total++; if ({s_req, s_we, s_wstrb} !== {1'b1, 1'b0, 8'h00}) begin bad++; $display("FAIL lw_req_we_strb got=%b/%b/%h exp=1/0/00", s_req, s_we, s_wstrb); end
    total++; if (stalls !== 2) begin bad++; $display("FAIL lw_stall got=%0d exp=2", stalls); end
    total++; if (d_lv !== 1'b1 || d_ld !== 64'hFFFF_FFFF_8000_0001 || d_li !== 5'd5) begin bad++; $display("FAIL lw_data got=%b/%h/%0d exp=1/ffffffff80000001/5", d_lv, d_ld, d_li); end
    total++; if (d_req !== 1'b0 || a_lv !== 1'b0) begin bad++; $display("FAIL lw_drop got=req%b/valid%b exp=0/0", d_req, a_lv); end
  endtask

  task automatic test_byte();
    run_op(1, 0, 3'b100, 64'h2003, 0, 7, 64'h0000_0000_AB00_0000, 1);
    total++; if (d_ld !== 64'hAB || d_li !== 5'd7) begin bad++; $display("FAIL lbu_data got=%h/%0d exp=ab/7", d_ld, d_li); end
    run_op(1, 0, 3'b000, 64'h2003, 0, 8, 64'h0000_0000_AB00_0000, 1);
    total++; if (d_ld !== 64'hFFFF_FFFF_FFFF_FFAB) begin bad++; $display("FAIL lb_data got=%h exp=ffffffffffffffab", d_ld); end
    run_op(1, 0, 3'b101, 64'h2002, 0, 9, 64'h0000_0000_8001_0000, 1);
    total++; if (d_ld !== 64'h8001) begin bad++; $display("FAIL lhu_data got=%h exp=8001", d_ld); end
  endtask

  task automatic test_sh();
    run_op(0, 1, 3'b001, 64'h3006, 64'hBEEF, 2, 0, 1);
    total++; if ({s_we, s_wstrb, s_addr} !== {1'b1, 8'hC0, 64'h3000}) begin bad++; $display("FAIL sh_ctl got=%b/%h/%h exp=1/c0/3000", s_we, s_wstrb, s_addr); end
    total++; if (s_wdata[63:48] !== 16'hBEEF) begin bad++; $display("FAIL sh_wdata got=%h exp=beef", s_wdata[63:48]); end
    total++; if (d_lv !== 1'b0 || a_lv !== 1'b0 || d_ld !== 64'h8001) begin bad++; $display("FAIL sh_noload got=%b/%b/%h exp=0/0/8001", d_lv, a_lv, d_ld); end
  endtask

  task automatic test_sd_wait();
    run_op(0, 1, 3'b011, 64'h4008, 64'h0123_4567_89AB_CDEF, 0, 0, 4);
    total++; if (stalls !== 5) begin bad++; $display("FAIL sd_stall got=%0d exp=5", stalls); end
    total++; if (stable !== 1'b1) begin bad++; $display("FAIL sd_stable got=%b exp=1", stable); end
    total++; if ({s_addr, s_wdata, s_wstrb} !== {64'h4008, 64'h0123_4567_89AB_CDEF, 8'hFF}) begin bad++; $display("FAIL sd_bus got=%h/%h/%h exp=4008/0123456789abcdef/ff", s_addr, s_wdata, s_wstrb); end
    total++; if (d_req !== 1'b0) begin bad++; $display("FAIL sd_req_fall got=%b exp=0", d_req); end
  endtask

  task automatic test_fault();
    run_op(1, 0, 3'b010, 64'h5002, 0, 4, 0, 1);
    total++; if ({f0, a_fault, a_req, d_req} !== 4'b1000 || stalls !== 0) begin bad++; $display("FAIL lw_misal got=f%b/%b req%b/%b stall%0d exp=1/0 0/0 0", f0, a_fault, a_req, d_req, stalls); end
    run_op(0, 1, 3'b100, 64'h5000, 0, 0, 0, 1);
    total++; if ({f0, a_fault, a_req, d_req} !== 4'b1000 || stalls !== 0) begin bad++; $display("FAIL st_illegal got=f%b/%b req%b/%b stall%0d exp=1/0 0/0 0", f0, a_fault, a_req, d_req, stalls); end
    run_op(1, 0, 3'b111, 64'h5000, 0, 0, 0, 1);
    total++; if ({f0, a_req} !== 2'b10 || stalls !== 0) begin bad++; $display("FAIL ld_illegal got=f%b req%b stall%0d exp=1/0/0", f0, a_req, stalls); end
  endtask

  task automatic test_stray_ack();
    @(negedge clk); bus_ack_i = 1; bus_rdata_i = 64'h55;
    @(negedge clk); bus_ack_i = 0;
    total++; if ({load_valid_o, lsu_stall_o, bus_req_o} !== 3'b000 || load_data_o !== 64'h8001) begin bad++; $display("FAIL stray_ack got=%b%b%b/%h exp=000/8001", load_valid_o, lsu_stall_o, bus_req_o, load_data_o); end
  endtask

  task automatic test_reset_busy();
    @(negedge clk);
    mem_read_i = 1; funct3_i = 3'b011; addr_i = 64'h6000; rsd_idx_i = 3;
    @(posedge clk); @(negedge clk);
    total++; if (bus_req_o !== 1'b1) begin bad++; $display("FAIL rb_busy got=%b exp=1", bus_req_o); end
    #2 rst = 1;
    #1;
    total++; if ({bus_req_o, lsu_stall_o, bus_addr_o} !== '0) begin bad++; $display("FAIL rb_abort got=%b/%b/%h exp=0/0/0", bus_req_o, lsu_stall_o, bus_addr_o); end
    mem_read_i = 0;
    @(negedge clk); rst = 0;
    run_op(1, 0, 3'b011, 64'h7008, 0, 9, 64'h1122_3344_5566_7788, 1);
    total++; if (stalls !== 2 || d_ld !== 64'h1122_3344_5566_7788 || d_li !== 5'd9 || s_addr !== 64'h7008) begin bad++; $display("FAIL rb_after got=%0d/%h/%0d/%h exp=2/1122334455667788/9/7008", stalls, d_ld, d_li, s_addr); end
  endtask

  initial begin
    test_reset();
    test_lw();
    test_byte();
    test_sh();
    test_sd_wait();
    test_fault();
    test_stray_ack();
    test_reset_busy();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/core_lsu.md
Name: core_lsu

Overview:
Load/store unit at the MEM stage. It consumes what the execute stage delivers through the EX/MEM register: the ALU result as the effective address, rs2 data as store data, funct3 and the destination index.
It drives a single-outstanding req/ack data-bus handshake and stalls the pipeline while an access is in flight. Load data is returned aligned and sign/zero-extended to the MEM/WB register.

Parameters:
XLEN, 64, operand/address width
BUS_W, 64, data bus width (fixed 8 byte lanes)

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-high
mem_read_i  in  1  load request from EX/MEM
mem_write_i  in  1  store request from EX/MEM (mutually exclusive with mem_read_i)
funct3_i  in  3  access size/sign code
addr_i  in  XLEN  effective address (ALU result)
wdata_i  in  XLEN  store data (rs2 data)
rsd_idx_i  in  5  load destination index
bus_req_o  out  1  bus request
bus_we_o  out  1  1=write
bus_addr_o  out  XLEN  doubleword-aligned address (addr[2:0]=0)
bus_wdata_o  out  BUS_W  lane-shifted store data
bus_wstrb_o  out  8  byte strobes
bus_ack_i  in  1  bus completion; bus_rdata_i valid in same cycle
bus_rdata_i  in  BUS_W  read data
lsu_stall_o  out  1  hold IF..EX/MEM
lsu_fault_o  out  1  misaligned/illegal access pulse
load_valid_o  out  1  load_data_o valid this cycle
load_data_o  out  XLEN  formatted load result
load_rsd_idx_o  out  5  destination index of load_data_o

Behaviour:
- Reset state: FSM=IDLE, bus_req_o=0, bus_we_o=0, bus_addr_o=0, bus_wdata_o=0, bus_wstrb_o=0, load_valid_o=0, load_data_o=0, load_rsd_idx_o=0. lsu_stall_o and lsu_fault_o are combinational and read 0 in reset.
- Sizes: funct3[1:0] is 00=B, 01=H, 10=W, 11=D. For loads, funct3[2]=1 means zero-extend. Illegal: load 111, or store with funct3[2]=1.
- Misaligned: H with off[0]!=0, W with off[1:0]!=0, D with off!=0, where off=addr_i[2:0].
- FSM states: IDLE, BUSY, DONE.
- IDLE, op (read|write) present, legal and aligned:
  - register bus_addr_o={addr_i[XLEN-1:3],3'b0}.
  - register bus_wdata_o=wdata_i<<(8*off).
  - register bus_wstrb_o=size_mask<<off, where size_mask is 01/03/0F/FF; strobes are 0 for loads.
  - register bus_we_o=mem_write_i; latch funct3, off and rsd_idx.
  - set bus_req_o=1 and go to BUSY. lsu_stall_o=1 in this cycle.
- IDLE, op present but illegal or misaligned: lsu_fault_o=1 (combinational), no bus request, lsu_stall_o=0, stay IDLE.
- BUSY:
  - bus_req_o and all bus outputs are held stable; lsu_stall_o=1.
  - on bus_ack_i: drop bus_req_o next cycle.
  - for a load, also register load_data_o = extend(bus_rdata_i>>(8*off), size, sign), set load_rsd_idx_o, and set load_valid_o=1.
  - then go to DONE. There is no timeout.
- DONE:
  - lsu_stall_o=0, so the pipeline advances at the end of this cycle.
  - inputs are ignored (the same instruction is still in EX/MEM).
  - load_valid_o drops next cycle; go to IDLE unconditionally.
- Minimum latency: accept at cycle 0, ack at cycle 1, DONE at cycle 2, so a 2-cycle stall. Each extra wait cycle before ack adds one stall cycle.
- bus_ack_i outside BUSY is ignored.
- Asynchronous rst in BUSY aborts the access and forces the reset values immediately. The bus slave must tolerate a request withdrawn without ack.
- load_data_o holds its last value when load_valid_o=0. A store never updates it.

Decomposition:
- Shared package/defines.v entries:
  - funct3 size codes (LSU_B/H/W/D, LSU_UNSIGNED bit).
  - FSM state encodings (2 bits).
  - LSU_STRB_WIDTH=8.
- Sub-module core_lsu_align: combinational; computes the store lane shift, strobes, misalignment/illegal check, and load extract/extend. It is shared by both paths.

Test Plan:
- LW x5 at addr 0x1004, rdata=0x8000_0001_1234_5678, ack after 1 cycle:
  - bus_addr_o=0x1000, strobes 0x00.
  - load_data_o=0xFFFF_FFFF_8000_0001, load_rsd_idx_o=5.
  - stall high for exactly 2 cycles.
- LBU at addr 0x2003, rdata=0x0000_0000_AB00_0000 -> load_data_o=0xAB. LB at the same address -> load_data_o=0xFFFF_FFFF_FFFF_FFAB.
- SH at addr 0x3006, data 0xBEEF -> bus_we_o=1, bus_wstrb_o=0xC0, bus_wdata_o[63:48]=0xBEEF; load_valid_o stays 0.
- SD at addr 0x4008 with ack delayed 4 cycles -> bus outputs stable throughout, stall high for 5 cycles, bus_req_o falls the cycle after ack.
- LW at addr 0x5002, and separately store with funct3=100 -> lsu_fault_o=1 for 1 cycle, bus_req_o stays 0, stall 0.
- Assert rst during BUSY of an LD -> bus_req_o=0 and state IDLE immediately; after release, a new LD completes normally.
